rgmii_rx_decode: RTL and testbench
==================================

// Module: rgmii_rx_decode
// PURPOSE
//  Consumes the 5-bit DDR capture {rx_ctl, rxd[3:0]} from the RX source-synchronous DDR input stage.
//  Converts it to GMII-style byte stream with dv/er and a per-byte valid strobe.
//  Speeds: 1G (byte per clk, both edges); 10/100 (one nibble per clk, rising edge only).
//  Decodes RGMII in-band link status during inter-frame gaps; feeds the Ethernet MAC RX path.
// PARAMETERS
//  INBAND_STABLE  2  consecutive idle cycles with identical status nibble before status regs update (1..15)
//  ODD_NIBBLE_ERR 1  1: frame ending on unpaired nibble emits a final byte with er=1; 0: partial nibble dropped
// PORTS
//  clk            in   1  RX clock (same clock as the DDR input stage output clock)
//  rst_n          in   1  asynchronous reset, active low
//  speed          in   2  00=10M, 01=100M, 10=1G, 11 treated as 1G
//  rx_q1          in   5  rising-edge capture {ctl, d[3:0]}
//  rx_q2          in   5  falling-edge capture {ctl, d[3:0]}
//  gmii_rxd       out  8  received byte
//  gmii_rx_dv     out  1  data valid
//  gmii_rx_er     out  1  receive error
//  gmii_rx_valid  out  1  byte strobe; outputs meaningful only when 1
//  link_up        out  1  in-band link status
//  link_speed     out  2  in-band speed (00/01/10)
//  link_duplex    out  1  in-band duplex (1=full)
// BEHAVIOUR
//  Reset: all outputs 0; nibble FSM in IDLE; active speed = 1G; stability counter 0.
//  Per-cycle decode: dv = rx_q1[4]; er = rx_q1[4] ^ rx_q2[4] (RGMII ctl encoding).
//  Active speed: latched from `speed` only while FSM is IDLE and dv=0.
//   A change of `speed` mid-frame is ignored until the frame ends.
//  1G mode: gmii_rxd={rx_q2[3:0],rx_q1[3:0]}, gmii_rx_dv=dv, gmii_rx_er=er, gmii_rx_valid=1.
//   All registered; latency 1 clk.
//  10/100 mode, FSM states IDLE, LOW, HIGH:
//   IDLE: dv=1 -> store rx_q1[3:0] as low nibble, OR er into sticky_er, go HIGH; else gmii_rx_valid=0.
//   HIGH: dv=1 -> emit {rx_q1[3:0],low}, dv=1, er=sticky_er|er, valid=1 next clk; clear sticky; go LOW.
//   HIGH: dv=0 -> odd-nibble end. ODD_NIBBLE_ERR=1: emit {4'h0,low}, dv=1, er=1, valid=1. Go IDLE.
//   LOW: dv=1 -> store low nibble, go HIGH; dv=0 -> go IDLE.
//   Entering IDLE from a frame: emit one byte with dv=0, er=0, valid=1 (end-of-frame marker).
//   In 10/100 mode, gmii_rx_valid pulses at most every 2nd clk during a frame; latency 1 clk after the high nibble.
//  Carrier/false-carrier: dv=0 & er=1 -> 1G: passed through (dv=0, er=1).
//   10/100: one byte with dv=0, er=1, rxd={rx_q1[3:0],rx_q1[3:0]}, valid=1; status not updated.
//  In-band status: candidate = rx_q1[3:0] when dv=0 & er=0.
//   Candidate equal to previous -> counter increments (saturating); else counter reloads to 1.
//   Counter reaching INBAND_STABLE -> link_up=cand[0], link_speed=cand[2:1], link_duplex=cand[3].
//   Any cycle with dv=1 or er=1 clears the counter; status regs hold.
//   cand[2:1]=11 is never loaded; status regs hold.
//  Async reset mid-frame: outputs drop to 0 immediately.
//   The next frame is accepted only after dv is seen low for 1 clk, so the frame tail is discarded.
// TESTING
//  1G: q1=5'h1_5, q2=5'h1_D for 8 clks -> rxd=8'hD5, dv=1, er=0, valid=1 each clk, 1 clk latency.
//  100M: nibbles 5,5,5,D via q1 with ctl=1 -> two bytes 8'h55, 8'hD5 on alternate clks; valid 0 between bytes.
//  100M, 3 nibbles then ctl=0 -> bytes 8'hxy, then {0,z} with er=1.
//   ODD_NIBBLE_ERR=0 -> only first byte, then end marker.
//  Idle q1=q2=5'h0_D for 2 clks -> link_up=1, link_speed=10, link_duplex=1.
//   Single-clk glitch to 5'h0_0 -> no status change.
//  Switch speed 1G->100M mid-frame -> frame completes in 1G format; 100M mode active on next frame.
//  1G: q1 ctl=1, q2 ctl=0 -> er=1 on that byte. Assert rst_n=0 mid-frame -> all outputs 0 same clk.

Source files
------------

// File: rtl/rgmii_rx_decode.sv
// RGMII RX decode: DDR {ctl,d} capture pairs to a GMII byte stream.
// 1G byte/clk or 10/100 nibble pairing; in-band link status in IFGs.
module rgmii_rx_decode #(
  parameter int INBAND_STABLE  = 2,
  parameter bit ODD_NIBBLE_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [4:0] rx_q1,
  input  logic [4:0] rx_q2,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_valid,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex
);

  localparam logic [3:0] STABLE = 4'(INBAND_STABLE);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } nib_t;

  nib_t       state;
  logic       dv;
  logic       er;
  logic       accept;
  logic       armed;
  logic       spd_1g;
  logic       sticky_er;
  logic       eof_pend;
  logic [3:0] low_nib;
  logic [3:0] cand_prev;
  logic [3:0] stab_cnt;
  logic [3:0] cnt_nxt;

  assign dv = rx_q1[4];
  assign er = rx_q1[4] ^ rx_q2[4];

  // After reset, a frame already in flight is dropped until dv goes low.
  assign accept = armed | ~dv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      spd_1g        <= 1'b1;
      sticky_er     <= 1'b0;
      eof_pend      <= 1'b0;
      low_nib       <= 4'h0;
      gmii_rxd      <= 8'h00;
      gmii_rx_dv    <= 1'b0;
      gmii_rx_er    <= 1'b0;
      gmii_rx_valid <= 1'b0;
    end else begin
      gmii_rx_valid <= 1'b0;
      if (!dv)
        armed <= 1'b1;
      // Speed only changes between frames.
      if (state == IDLE && !dv)
        spd_1g <= speed[1];
      if (!accept) begin
        state <= IDLE;
      end else if (spd_1g) begin
        gmii_rxd      <= {rx_q2[3:0], rx_q1[3:0]};
        gmii_rx_dv    <= dv;
        gmii_rx_er    <= er;
        gmii_rx_valid <= 1'b1;
        eof_pend      <= 1'b0;
        state         <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (eof_pend) begin
              gmii_rxd      <= 8'h00;
              gmii_rx_dv    <= 1'b0;
              gmii_rx_er    <= 1'b0;
              gmii_rx_valid <= 1'b1;
              eof_pend      <= 1'b0;
            end else if (!dv && er) begin
              gmii_rxd      <= {rx_q1[3:0], rx_q1[3:0]};
              gmii_rx_dv    <= 1'b0;
              gmii_rx_er    <= 1'b1;
              gmii_rx_valid <= 1'b1;
            end
            if (dv) begin
              low_nib   <= rx_q1[3:0];
              sticky_er <= sticky_er | er;
              state     <= HIGH;
            end
          end
          HIGH: begin
            sticky_er <= 1'b0;
            if (dv) begin
              gmii_rxd      <= {rx_q1[3:0], low_nib};
              gmii_rx_dv    <= 1'b1;
              gmii_rx_er    <= sticky_er | er;
              gmii_rx_valid <= 1'b1;
              state         <= LOW;
            end else begin
              state         <= IDLE;
              gmii_rx_valid <= 1'b1;
              if (ODD_NIBBLE_ERR) begin
                // End marker follows on the next clk.
                gmii_rxd   <= {4'h0, low_nib};
                gmii_rx_dv <= 1'b1;
                gmii_rx_er <= 1'b1;
                eof_pend   <= 1'b1;
              end else begin
                gmii_rxd   <= 8'h00;
                gmii_rx_dv <= 1'b0;
                gmii_rx_er <= 1'b0;
              end
            end
          end
          LOW: begin
            if (dv) begin
              low_nib   <= rx_q1[3:0];
              sticky_er <= sticky_er | er;
              state     <= HIGH;
            end else begin
              gmii_rxd      <= 8'h00;
              gmii_rx_dv    <= 1'b0;
              gmii_rx_er    <= 1'b0;
              gmii_rx_valid <= 1'b1;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Run length of identical status nibbles; zero means no run yet.
  always_comb begin
    cnt_nxt = 4'd1;
    if (stab_cnt != 4'd0 && rx_q1[3:0] == cand_prev)
      cnt_nxt = (stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_prev   <= 4'h0;
      stab_cnt    <= 4'h0;
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      link_duplex <= 1'b0;
    end else if (dv || er) begin
      stab_cnt <= 4'h0;
    end else begin
      stab_cnt  <= cnt_nxt;
      cand_prev <= rx_q1[3:0];
      if (cnt_nxt == STABLE && rx_q1[2:1] != 2'b11) begin
        link_up     <= rx_q1[0];
        link_speed  <= rx_q1[2:1];
        link_duplex <= rx_q1[3];
      end
    end
  end

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode.
// Second instance runs with the partial nibble dropped.
module tb_rgmii_rx_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] speed = 2'b10;
  logic [4:0] rx_q1 = 5'h00;
  logic [4:0] rx_q2 = 5'h00;

  logic [7:0] rxd;
  logic       rdv, rer, rvld, lup, ldup;
  logic [1:0] lspd;
  logic [7:0] rxd0;
  logic       rdv0, rer0, rvld0, lup0, ldup0;
  logic [1:0] lspd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rgmii_rx_decode #(.INBAND_STABLE(2), .ODD_NIBBLE_ERR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .rx_q1(rx_q1), .rx_q2(rx_q2),
    .gmii_rxd(rxd), .gmii_rx_dv(rdv), .gmii_rx_er(rer),
    .gmii_rx_valid(rvld), .link_up(lup),
    .link_speed(lspd), .link_duplex(ldup)
  );

  rgmii_rx_decode #(.INBAND_STABLE(2), .ODD_NIBBLE_ERR(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .rx_q1(rx_q1), .rx_q2(rx_q2),
    .gmii_rxd(rxd0), .gmii_rx_dv(rdv0), .gmii_rx_er(rer0),
    .gmii_rx_valid(rvld0), .link_up(lup0),
    .link_speed(lspd0), .link_duplex(ldup0)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d,
                         input logic v, input logic e, input logic s);
    chk({tag, ".valid"}, {7'd0, rvld}, {7'd0, s});
    if (s) begin
      chk({tag, ".rxd"}, rxd, d);
      chk({tag, ".dv"}, {7'd0, rdv}, {7'd0, v});
      chk({tag, ".er"}, {7'd0, rer}, {7'd0, e});
    end
  endtask

  task automatic chk_link(input string tag, input logic u,
                          input logic [1:0] sp, input logic dx);
    chk({tag, ".up"}, {7'd0, lup}, {7'd0, u});
    chk({tag, ".spd"}, {6'd0, lspd}, {6'd0, sp});
    chk({tag, ".dup"}, {7'd0, ldup}, {7'd0, dx});
  endtask

  task automatic step(input logic [4:0] q1, input logic [4:0] q2);
    @(negedge clk);
    rx_q1 = q1;
    rx_q2 = q2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rxd", rxd, 8'h00);
    chk("rst.dv", {7'd0, rdv}, 8'h00);
    chk("rst.er", {7'd0, rer}, 8'h00);
    chk("rst.valid", {7'd0, rvld}, 8'h00);
    chk_link("rst", 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // In-band status, 1G idle
    step(5'h0D, 5'h0D);
    chk_out("idle1", 8'hDD, 1'b0, 1'b0, 1'b1);
    chk_link("st1", 1'b0, 2'b00, 1'b0);
    step(5'h0D, 5'h0D);
    chk_link("st2", 1'b1, 2'b10, 1'b1);
    step(5'h00, 5'h00);
    chk_link("glitch", 1'b1, 2'b10, 1'b1);
    step(5'h0D, 5'h0D);
    step(5'h07, 5'h07);
    step(5'h07, 5'h07);
    chk_link("spd11", 1'b1, 2'b10, 1'b1);
    step(5'h02, 5'h02);
    step(5'h02, 5'h02);
    chk_link("st_02", 1'b0, 2'b01, 1'b0);

    // 1G frame with a speed change to 100M mid-frame
    for (int i = 0; i < 8; i++) begin
      if (i == 4)
        speed = 2'b01;
      step(5'h15, 5'h1D);
      chk_out("g1", 8'hD5, 1'b1, 1'b0, 1'b1);
    end
    step(5'h15, 5'h0D);
    chk_out("g1er", 8'hD5, 1'b1, 1'b1, 1'b1);
    step(5'h02, 5'h02);
    chk_out("g1end", 8'h22, 1'b0, 1'b0, 1'b1);
    chk_link("g1st", 1'b0, 2'b01, 1'b0);

    // 100M frame: 5,5,5,D
    step(5'h15, 5'h15);
    chk_out("m1a", 8'h00, 1'b0, 1'b0, 1'b0);
    step(5'h15, 5'h15);
    chk_out("m1b", 8'h55, 1'b1, 1'b0, 1'b1);
    step(5'h15, 5'h15);
    chk_out("m1c", 8'h00, 1'b0, 1'b0, 1'b0);
    step(5'h1D, 5'h1D);
    chk_out("m1d", 8'hD5, 1'b1, 1'b0, 1'b1);
    step(5'h02, 5'h02);
    chk_out("m1eof", 8'h00, 1'b0, 1'b0, 1'b1);
    step(5'h02, 5'h02);
    chk_out("m1idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 100M odd-nibble frame: 1,2,3 then ctl low
    step(5'h11, 5'h11);
    step(5'h12, 5'h12);
    chk_out("m2a", 8'h21, 1'b1, 1'b0, 1'b1);
    step(5'h13, 5'h13);
    chk_out("m2b", 8'h00, 1'b0, 1'b0, 1'b0);
    step(5'h02, 5'h02);
    chk_out("m2odd", 8'h03, 1'b1, 1'b1, 1'b1);
    chk("m2odd0.valid", {7'd0, rvld0}, 8'h01);
    chk("m2odd0.dv", {7'd0, rdv0}, 8'h00);
    step(5'h02, 5'h02);
    chk_out("m2eof", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("m2eof0.valid", {7'd0, rvld0}, 8'h00);

    // 100M error in the low nibble is carried into the byte
    step(5'h14, 5'h04);
    step(5'h16, 5'h16);
    chk_out("m3", 8'h64, 1'b1, 1'b1, 1'b1);
    step(5'h02, 5'h02);
    chk_out("m3eof", 8'h00, 1'b0, 1'b0, 1'b1);

    // 100M false carrier
    step(5'h0E, 5'h1E);
    chk_out("fc", 8'hEE, 1'b0, 1'b1, 1'b1);
    chk_link("fcst", 1'b0, 2'b01, 1'b0);

    // Back to 1G, then reset mid-frame
    speed = 2'b10;
    step(5'h02, 5'h02);
    step(5'h15, 5'h1D);
    chk_out("g2", 8'hD5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.rxd", rxd, 8'h00);
    chk("arst.dv", {7'd0, rdv}, 8'h00);
    chk("arst.valid", {7'd0, rvld}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'h15, 5'h1D);
    chk_out("tail", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("tail.dv", {7'd0, rdv}, 8'h00);
    step(5'h02, 5'h02);
    chk_out("rearm", 8'h22, 1'b0, 1'b0, 1'b1);
    step(5'h15, 5'h1D);
    chk_out("g3", 8'hD5, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
